// File: rtl/proc_core_gen_pkg.sv
// Shared opcode/state encodings and instruction field widths for the accumulator core.
package proc_core_gen_pkg;

    localparam int unsigned OpBits  = 4;
    localparam int unsigned RegBits = 4;

    typedef enum logic [OpBits-1:0] {
        OpNop  = 4'h0,
        OpLdi  = 4'h1,
        OpLd   = 4'h2,
        OpSt   = 4'h3,
        OpMovr = 4'h4,
        OpMova = 4'h5,
        OpAdd  = 4'h6,
        OpSub  = 4'h7,
        OpMul  = 4'h8,
        OpIncr = 4'h9,
        OpJz   = 4'hA,
        OpJmp  = 4'hB,
        OpCmp  = 4'hC,
        OpLdr  = 4'hD,
        OpStr  = 4'hE,
        OpHalt = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StExec   = 2'd1,
        StMem    = 2'd2,
        StHalted = 2'd3
    } state_e;

endpackage

// File: rtl/proc_core_gen_regfile.sv
// General register file: one shared read/write index, write or increment-in-place.
module proc_core_gen_regfile
    import proc_core_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RegBits-1:0] addr,
    output logic [WIDTH-1:0]   rdata,
    input  logic               we,
    input  logic               inc,
    input  logic [WIDTH-1:0]   wdata
);

    logic [WIDTH-1:0] regs_q [NREG];

    // Indices at or above NREG match no entry: reads give 0, writes vanish.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (addr == RegBits'(i)) rdata = regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (addr == RegBits'(i)) begin
                    if (we) begin
                        regs_q[i] <= wdata;
                    end else if (inc) begin
                        regs_q[i] <= regs_q[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/proc_core_gen.sv
// Multicycle accumulator core with req/ack instruction fetch and data access.
module proc_core_gen
    import proc_core_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned NREG  = 8,
    parameter int unsigned IW    = AW + 8
) (
    input  logic             Clk,
    input  logic             Rst,
    output logic             irom_req,
    output logic [AW-1:0]    irom_addr,
    input  logic             irom_ack,
    input  logic [IW-1:0]    irom_data,
    output logic             dram_req,
    output logic             dram_we,
    output logic [AW-1:0]    dram_addr,
    output logic [WIDTH-1:0] dram_wdata,
    input  logic             dram_ack,
    input  logic [WIDTH-1:0] dram_rdata,
    output logic             halted,
    output logic             zflag
);

    state_e             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d, maddr_q, maddr_d;
    logic [WIDTH-1:0]   ac_q, ac_d, alu_res;
    logic [IW-1:0]      ir_q, ir_d;
    logic               z_q, z_d, mwe_q, mwe_d;
    logic               rf_we, rf_inc;
    logic [WIDTH-1:0]   rf_rdata;
    opcode_e            op;
    logic [RegBits-1:0] rsel;
    logic [AW-1:0]      imm;

    assign op   = opcode_e'(ir_q[IW-1 -: OpBits]);
    assign rsel = ir_q[IW-OpBits-1 -: RegBits];
    assign imm  = ir_q[AW-1:0];

    proc_core_gen_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk   (Clk),
        .rst   (Rst),
        .addr  (rsel),
        .rdata (rf_rdata),
        .we    (rf_we),
        .inc   (rf_inc),
        .wdata (ac_q)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ac_q    <= '0;
            z_q     <= 1'b0;
            ir_q    <= '0;
            maddr_q <= '0;
            mwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            z_q     <= z_d;
            ir_q    <= ir_d;
            maddr_q <= maddr_d;
            mwe_q   <= mwe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        z_d     = z_q;
        ir_d    = ir_q;
        maddr_d = maddr_q;
        mwe_d   = mwe_q;
        rf_we   = 1'b0;
        rf_inc  = 1'b0;
        alu_res = '0;
        unique case (state_q)
            StFetch: begin
                if (irom_ack) begin
                    ir_d    = irom_data;
                    pc_d    = pc_q + AW'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpLdi: ac_d = WIDTH'(imm);
                    OpLd, OpSt: begin
                        maddr_d = imm;
                        mwe_d   = (op == OpSt);
                        state_d = StMem;
                    end
                    OpLdr, OpStr: begin
                        maddr_d = AW'(rf_rdata);
                        mwe_d   = (op == OpStr);
                        state_d = StMem;
                    end
                    OpMovr: rf_we = 1'b1;
                    OpMova: ac_d = rf_rdata;
                    OpAdd, OpSub, OpMul: begin
                        if (op == OpAdd)      alu_res = ac_q + rf_rdata;
                        else if (op == OpSub) alu_res = ac_q - rf_rdata;
                        else                  alu_res = ac_q * rf_rdata;
                        ac_d = alu_res;
                        z_d  = (alu_res == '0);
                    end
                    OpIncr: rf_inc = 1'b1;
                    OpJz:   if (z_q) pc_d = imm;
                    OpJmp:  pc_d = imm;
                    OpCmp:  z_d = (ac_q == rf_rdata);
                    OpHalt: state_d = StHalted;
                    default: ;
                endcase
            end
            StMem: begin
                if (dram_ack) begin
                    if (!mwe_q) ac_d = dram_rdata;
                    state_d = StFetch;
                end
            end
            StHalted: ;
            default: state_d = StFetch;
        endcase
    end

    // Request is held low while reset is asserted so it rises only once reset releases.
    assign irom_req   = (state_q == StFetch) && !Rst;
    assign irom_addr  = pc_q;
    assign dram_req   = (state_q == StMem);
    assign dram_we    = mwe_q;
    assign dram_addr  = maddr_q;
    assign dram_wdata = ac_q;
    assign halted     = (state_q == StHalted);
    assign zflag      = z_q;

endmodule

// File: tb/tb_proc_core_gen.sv
// Scoreboarded bench: main core (WIDTH 8, AW 8, NREG 4) plus an AW=4 core for PC wrap.
module tb_proc_core_gen;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic        irom_req, irom_ack, dram_req, dram_we, dram_ack, halted, zflag;
    logic [7:0]  irom_addr, dram_addr, dram_wdata, dram_rdata;
    logic [15:0] irom_data;

    logic        irom_req4, irom_ack4, dram_req4, dram_we4, halted4, zflag4;
    logic [3:0]  irom_addr4, dram_addr4;
    logic [7:0]  dram_wdata4;
    logic        rom4_en = 1'b1;
    logic        dram_ack4 = 1'b0;

    logic [15:0] rom [256];
    logic [7:0]  dmem [256];
    int          irom_lat = 0, dram_lat = 0, irom_cnt = 0, dram_cnt = 0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0, load_data = '0;
    logic [15:0] exp_q[$], obs_q[$];
    int          checks = 0, errors = 0;

    assign irom_ack   = irom_req && (irom_cnt >= irom_lat);
    assign irom_data  = rom[irom_addr];
    assign dram_ack   = dram_req && (dram_cnt >= dram_lat);
    assign dram_rdata = dmem[dram_addr];
    assign irom_ack4  = irom_req4 && rom4_en;

    always @(posedge Clk) begin
        irom_cnt <= (irom_req && !irom_ack) ? irom_cnt + 1 : 0;
        dram_cnt <= (dram_req && !dram_ack) ? dram_cnt + 1 : 0;
        if (load_en) dmem[load_addr] <= load_data;
        if (dram_req && dram_ack && dram_we) begin
            dmem[dram_addr] <= dram_wdata;
            obs_q.push_back({dram_addr, dram_wdata});
        end
    end

    proc_core_gen #(.WIDTH(8), .AW(8), .NREG(4)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .irom_req(irom_req), .irom_addr(irom_addr), .irom_ack(irom_ack), .irom_data(irom_data),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_ack(dram_ack), .dram_rdata(dram_rdata), .halted(halted), .zflag(zflag)
    );

    proc_core_gen #(.WIDTH(8), .AW(4), .NREG(8)) u_pc4 (
        .Clk(Clk), .Rst(Rst),
        .irom_req(irom_req4), .irom_addr(irom_addr4), .irom_ack(irom_ack4), .irom_data(12'h000),
        .dram_req(dram_req4), .dram_we(dram_we4), .dram_addr(dram_addr4), .dram_wdata(dram_wdata4),
        .dram_ack(dram_ack4), .dram_rdata(8'h00), .halted(halted4), .zflag(zflag4)
    );

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] r,
                                        input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    // Holds reset, clears models and fills the ROM with HALT.
    task automatic clear_env();
        Rst = 1'b1;
        irom_lat = 0;
        dram_lat = 0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        @(posedge Clk); #1;
        obs_q.delete();
    endtask

    task automatic run_to_halt(input int bound, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < bound) begin
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_env();
        checks += 8;
        if (irom_req !== 1'b0) begin errors++; $display("FAIL rst_irom_req got %b exp 0", irom_req); end
        if (irom_addr !== 8'h00) begin errors++; $display("FAIL rst_irom_addr got %h exp 00", irom_addr); end
        if (dram_req !== 1'b0) begin errors++; $display("FAIL rst_dram_req got %b exp 0", dram_req); end
        if (dram_we !== 1'b0) begin errors++; $display("FAIL rst_dram_we got %b exp 0", dram_we); end
        if (dram_addr !== 8'h00) begin errors++; $display("FAIL rst_dram_addr got %h exp 00", dram_addr); end
        if (dram_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata got %h exp 00", dram_wdata); end
        if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
        if (zflag !== 1'b0) begin errors++; $display("FAIL rst_zflag got %b exp 0", zflag); end
        Rst = 1'b0;
        #1;
        checks += 2;
        if (irom_req !== 1'b1) begin errors++; $display("FAIL rel_irom_req got %b exp 1", irom_req); end
        if (irom_addr !== 8'h00) begin errors++; $display("FAIL rel_irom_addr got %h exp 00", irom_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        clear_env();
        rom[0] = ins(4'h1, 4'h0, 8'h33);
        for (int i = 1; i < 8; i++) rom[i] = 16'h0000;
        Rst = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        irom_lat = 50;
        @(posedge Clk); #1;
        checks += 3;
        if (irom_req !== 1'b1) begin errors++; $display("FAIL mid_req_pending got %b exp 1", irom_req); end
        if (irom_addr !== 8'h03) begin errors++; $display("FAIL mid_pc_before got %h exp 03", irom_addr); end
        if (dram_wdata !== 8'h33) begin errors++; $display("FAIL mid_ac_before got %h exp 33", dram_wdata); end
        Rst = 1'b1;
        @(posedge Clk); #1;
        checks += 3;
        if (irom_req !== 1'b0) begin errors++; $display("FAIL mid_req_in_rst got %b exp 0", irom_req); end
        if (irom_addr !== 8'h00) begin errors++; $display("FAIL mid_pc_in_rst got %h exp 00", irom_addr); end
        if (dram_wdata !== 8'h00) begin errors++; $display("FAIL mid_ac_in_rst got %h exp 00", dram_wdata); end
        irom_lat = 0;
        Rst = 1'b0;
        #1;
        checks += 1;
        if (irom_req !== 1'b1 || irom_addr !== 8'h00) begin
            errors++; $display("FAIL mid_refetch got req %b addr %h exp req 1 addr 00", irom_req, irom_addr);
        end
    endtask

    task automatic test_zero_wait();
        logic [15:0] e, o;
        clear_env();
        rom[0] = ins(4'h1, 4'h0, 8'h05);
        rom[1] = ins(4'h4, 4'h1, 8'h00);
        rom[2] = ins(4'h6, 4'h1, 8'h00);
        rom[3] = ins(4'h3, 4'h0, 8'h10);
        rom[4] = ins(4'hF, 4'h0, 8'h00);
        exp_q.push_back({8'h10, 8'h0A});
        Rst = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL zw_halted_c10 got %b exp 0", halted); end
        @(posedge Clk); #1;
        checks += 2;
        if (halted !== 1'b1) begin errors++; $display("FAIL zw_halted_c11 got %b exp 1", halted); end
        if (zflag !== 1'b0) begin errors++; $display("FAIL zw_zflag got %b exp 0", zflag); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL zw_write got none exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL zw_write got %h exp %h", o, e); end end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL zw_extra got %0d writes exp 0", obs_q.size()); end
    endtask

    task automatic test_delayed_ld();
        logic [15:0] e, o;
        int cyc, req_cyc, bad;
        clear_env();
        load_addr = 8'h20; load_data = 8'h7F; load_en = 1'b1;
        @(posedge Clk); #1;
        load_en = 1'b0;
        dram_lat = 4;
        rom[0] = ins(4'h2, 4'h0, 8'h20);
        rom[1] = ins(4'h3, 4'h0, 8'h30);
        exp_q.push_back({8'h30, 8'h7F});
        Rst = 1'b0;
        cyc = 0; req_cyc = 0; bad = 0;
        while (halted !== 1'b1 && cyc < 200) begin
            if (dram_req === 1'b1 && dram_we === 1'b0) begin
                req_cyc++;
                if (dram_addr !== 8'h20) bad++;
            end
            @(posedge Clk); #1;
            cyc++;
        end
        checks += 3;
        if (cyc >= 200) begin errors++; $display("FAIL dl_timeout got %0d cycles exp <200", cyc); end
        if (req_cyc != 5) begin errors++; $display("FAIL dl_req_cycles got %0d exp 5", req_cyc); end
        if (bad != 0) begin errors++; $display("FAIL dl_addr_stable got %0d bad exp 0", bad); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL dl_write got none exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL dl_write got %h exp %h", o, e); end end
        end
    endtask

    task automatic test_wrap_jz();
        logic [15:0] e, o;
        int cyc;
        logic saw40;
        clear_env();
        rom[0] = ins(4'h1, 4'h0, 8'hFF);
        rom[1] = ins(4'h4, 4'h2, 8'h00);
        rom[2] = ins(4'h1, 4'h0, 8'h01);
        rom[3] = ins(4'h6, 4'h2, 8'h00);
        rom[4] = ins(4'h3, 4'h0, 8'h50);
        rom[5] = ins(4'hA, 4'h0, 8'h40);
        rom[6] = ins(4'hB, 4'h0, 8'h06);
        exp_q.push_back({8'h50, 8'h00});
        Rst = 1'b0;
        cyc = 0; saw40 = 1'b0;
        while (halted !== 1'b1 && cyc < 200) begin
            if (irom_req === 1'b1 && irom_addr === 8'h40) saw40 = 1'b1;
            @(posedge Clk); #1;
            cyc++;
        end
        checks += 3;
        if (cyc >= 200) begin errors++; $display("FAIL wr_timeout got %0d cycles exp <200", cyc); end
        if (saw40 !== 1'b1) begin errors++; $display("FAIL wr_jz_target got %b exp 1", saw40); end
        if (zflag !== 1'b1) begin errors++; $display("FAIL wr_zflag got %b exp 1", zflag); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL wr_write got none exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL wr_write got %h exp %h", o, e); end end
        end
    endtask

    task automatic test_alu_indirect();
        logic [15:0] e, o, prog [22];
        int cyc;
        clear_env();
        prog = '{ins(4'h1, 4'h0, 8'h06), ins(4'h4, 4'h3, 8'h00), ins(4'h1, 4'h0, 8'h07),
                 ins(4'h8, 4'h3, 8'h00), ins(4'h3, 4'h0, 8'h60), ins(4'h7, 4'h3, 8'h00),
                 ins(4'h3, 4'h0, 8'h61), ins(4'hC, 4'h3, 8'h00), ins(4'h5, 4'h3, 8'h00),
                 ins(4'hC, 4'h3, 8'h00), ins(4'h9, 4'h3, 8'h00), ins(4'h5, 4'h3, 8'h00),
                 ins(4'h3, 4'h0, 8'h62), ins(4'h1, 4'h0, 8'h61), ins(4'h4, 4'h0, 8'h00),
                 ins(4'hD, 4'h0, 8'h00), ins(4'h3, 4'h0, 8'h63), ins(4'h1, 4'h0, 8'h70),
                 ins(4'h4, 4'h1, 8'h00), ins(4'h1, 4'h0, 8'h5A), ins(4'hE, 4'h1, 8'h00),
                 ins(4'hF, 4'h0, 8'h00)};
        for (int i = 0; i < 22; i++) rom[i] = prog[i];
        exp_q.push_back({8'h60, 8'h2A});
        exp_q.push_back({8'h61, 8'h24});
        exp_q.push_back({8'h62, 8'h07});
        exp_q.push_back({8'h63, 8'h24});
        exp_q.push_back({8'h70, 8'h5A});
        dram_lat = 1;
        Rst = 1'b0;
        run_to_halt(400, cyc);
        checks += 2;
        if (cyc >= 400) begin errors++; $display("FAIL alu_timeout got %0d cycles exp <400", cyc); end
        if (zflag !== 1'b1) begin errors++; $display("FAIL alu_zflag got %b exp 1", zflag); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL alu_write got none exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL alu_write got %h exp %h", o, e); end end
        end
    endtask

    task automatic test_nreg_range();
        logic [15:0] e, o;
        int cyc, pc;
        logic [7:0] vals [4];
        clear_env();
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        pc = 0;
        for (int i = 0; i < 4; i++) begin
            rom[pc] = ins(4'h1, 4'h0, vals[i]); rom[pc+1] = ins(4'h4, 4'(i), 8'h00); pc += 2;
        end
        rom[pc] = ins(4'h1, 4'h0, 8'h99); rom[pc+1] = ins(4'h4, 4'h7, 8'h00);
        rom[pc+2] = ins(4'h1, 4'h0, 8'h55); rom[pc+3] = ins(4'h5, 4'h7, 8'h00);
        rom[pc+4] = ins(4'h3, 4'h0, 8'h80); pc += 5;
        exp_q.push_back({8'h80, 8'h00});
        for (int i = 0; i < 4; i++) begin
            rom[pc] = ins(4'h5, 4'(i), 8'h00); rom[pc+1] = ins(4'h3, 4'h0, 8'(8'h81 + i)); pc += 2;
            exp_q.push_back({8'(8'h81 + i), vals[i]});
        end
        rom[pc] = ins(4'h9, 4'h7, 8'h00); rom[pc+1] = ins(4'h5, 4'h7, 8'h00);
        rom[pc+2] = ins(4'h3, 4'h0, 8'h85);
        exp_q.push_back({8'h85, 8'h00});
        Rst = 1'b0;
        run_to_halt(400, cyc);
        checks++;
        if (cyc >= 400) begin errors++; $display("FAIL nreg_timeout got %0d cycles exp <400", cyc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL nreg_write got none exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL nreg_write got %h exp %h", o, e); end end
        end
    endtask

    task automatic test_pc_wrap_aw4();
        int cyc;
        rom4_en = 1'b1;
        dram_ack4 = 1'b0;
        cyc = 0;
        while (!(irom_req4 === 1'b1 && irom_addr4 === 4'hF) && cyc < 60) begin
            @(posedge Clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 60) begin errors++; $display("FAIL pc4_find15 got %0d cycles exp <60", cyc); end
        @(posedge Clk); #1;
        checks++;
        if (irom_req4 !== 1'b0) begin errors++; $display("FAIL pc4_exec got req %b exp 0", irom_req4); end
        @(posedge Clk); #1;
        checks++;
        if (irom_req4 !== 1'b1 || irom_addr4 !== 4'h0) begin
            errors++; $display("FAIL pc4_wrap got req %b addr %h exp req 1 addr 0", irom_req4, irom_addr4);
        end
        rom4_en = 1'b0;
        dram_ack4 = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks += 3;
        if (irom_req4 !== 1'b1 || irom_addr4 !== 4'h0) begin
            errors++; $display("FAIL pc4_spurious got req %b addr %h exp req 1 addr 0", irom_req4, irom_addr4);
        end
        if (dram_req4 !== 1'b0) begin errors++; $display("FAIL pc4_dram_req got %b exp 0", dram_req4); end
        if (halted4 !== 1'b0) begin errors++; $display("FAIL pc4_halted got %b exp 0", halted4); end
        rom4_en = 1'b1;
        dram_ack4 = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (irom_req4 !== 1'b0) begin errors++; $display("FAIL pc4_resume got req %b exp 0", irom_req4); end
        @(posedge Clk); #1;
        checks++;
        if (irom_addr4 !== 4'h1) begin errors++; $display("FAIL pc4_next got %h exp 1", irom_addr4); end
    endtask

    initial begin
        test_reset();
        test_pc_wrap_aw4();
        test_reset_mid_fetch();
        test_zero_wait();
        test_delayed_ld();
        test_wrap_jz();
        test_alu_indirect();
        test_nreg_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
